// File: rtl/clock_time_ctrl_if.sv
// Bus between the clock sequencing controller and the H:M:S counter chain / user inputs.
interface clock_time_ctrl_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_inc;
  logic       sec_co;
  logic       min_co;
  logic       sec_en;
  logic       min_en;
  logic       hr_en;
  logic       sec_clr;
  logic [1:0] mode;
  logic [2:0] blink_mask;
  logic       running;

  modport master (
    input  tick, btn_mode, btn_inc, sec_co, min_co,
    output sec_en, min_en, hr_en, sec_clr, mode, blink_mask, running
  );

  modport slave (
    output tick, btn_mode, btn_inc, sec_co, min_co,
    input  sec_en, min_en, hr_en, sec_clr, mode, blink_mask, running
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// Sequencing controller for the hour/minute/second BCD chain: routes tick/carries in
// run mode, steers increment pulses (with hold-to-repeat) while setting, and blinks
// the field being set.
//
// state   | meaning
// RUN     | timekeeping; tick and carry-outs drive the counter enables
// SET_HR  | clock frozen; inc pulses step the hours counter
// SET_MIN | clock frozen; inc pulses step minutes, minute wrap never reaches hours
// SET_SEC | clock frozen; inc pulses clear the seconds counter
module clock_time_ctrl #(
  parameter int unsigned      CNT_W      = 24,
  parameter logic [CNT_W-1:0] HOLD_CYC   = 24'd5000000,
  parameter logic [CNT_W-1:0] REPEAT_CYC = 24'd1000000,
  parameter logic [CNT_W-1:0] BLINK_CYC  = 24'd2500000
) (
  input  logic              clk,
  input  logic              r,
  clock_time_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    SET_SEC = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             btn_prev;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
  logic [CNT_W-1:0] blink_cnt, blink_cnt_d;
  logic             phase_q, phase_d;   // 1 = field blanked
  logic [2:0]       mask_q, mask_d;
  logic             running_q;
  logic             inc_edge, inc_rpt, inc, inc_eff, blink_clr;
  logic             sec_en, min_en, hr_en, sec_clr;

  // Press edge gives the first pulse; later pulses come when the hold timer expires.
  assign inc_edge = bus.btn_inc & ~btn_prev;
  assign inc_rpt  = bus.btn_inc & btn_prev & (hold_cnt == '0);
  assign inc      = inc_edge | inc_rpt;
  assign inc_eff  = inc & (state_q != RUN);

  // Hold/repeat down-counter: HOLD_CYC after the press edge, then REPEAT_CYC per pulse.
  always_comb begin
    hold_cnt_d = hold_cnt;
    if (!bus.btn_inc) begin
      hold_cnt_d = '0;
    end else if (inc_edge) begin
      hold_cnt_d = HOLD_CYC - ONE;
    end else if (inc_rpt) begin
      hold_cnt_d = REPEAT_CYC - ONE;
    end else begin
      hold_cnt_d = hold_cnt - ONE;
    end
  end

  // Mode sequencing and enable steering; enables use the current state, zero latency.
  always_comb begin
    state_d = state_q;
    sec_en  = 1'b0;
    min_en  = 1'b0;
    hr_en   = 1'b0;
    sec_clr = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.btn_mode) state_d = SET_HR;
        sec_en = bus.tick;
        min_en = bus.sec_co;
        hr_en  = bus.min_co;
      end
      SET_HR: begin
        if (bus.btn_mode) state_d = SET_MIN;
        hr_en = inc;
      end
      SET_MIN: begin
        if (bus.btn_mode) state_d = SET_SEC;
        min_en = inc;
      end
      SET_SEC: begin
        if (bus.btn_mode) state_d = RUN;
        sec_clr = inc;
      end
    endcase
  end

  // Blink timer: restart lit on any state change or effective inc, toggle each half-period.
  assign blink_clr = (state_d != state_q) | inc_eff;

  always_comb begin
    blink_cnt_d = blink_cnt - ONE;
    phase_d     = phase_q;
    if (blink_clr || state_q == RUN) begin
      blink_cnt_d = BLINK_CYC - ONE;
      phase_d     = 1'b0;
    end else if (blink_cnt == '0) begin
      blink_cnt_d = BLINK_CYC - ONE;
      phase_d     = ~phase_q;
    end
  end

  // Next blink mask: one-hot of the selected field while blanked.
  always_comb begin
    mask_d = 3'b000;
    if (phase_d) begin
      case (state_d)
        SET_HR:  mask_d = 3'b100;
        SET_MIN: mask_d = 3'b010;
        SET_SEC: mask_d = 3'b001;
        default: mask_d = 3'b000;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge r) begin
    if (!r) state_q <= RUN;
    else    state_q <= state_d;
  end

  // Increment-button history and hold timer.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      btn_prev <= 1'b0;
      hold_cnt <= '0;
    end else begin
      btn_prev <= bus.btn_inc;
      hold_cnt <= hold_cnt_d;
    end
  end

  // Blink timer and phase.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      blink_cnt <= '0;
      phase_q   <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_d;
      phase_q   <= phase_d;
    end
  end

  // Registered status outputs so the display side sees glitch-free values.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      mask_q    <= 3'b000;
      running_q <= 1'b1;
    end else begin
      mask_q    <= mask_d;
      running_q <= (state_d == RUN);
    end
  end

  // Enables are forced off while reset is asserted, independent of the clock.
  assign bus.sec_en     = r & sec_en;
  assign bus.min_en     = r & min_en;
  assign bus.hr_en      = r & hr_en;
  assign bus.sec_clr    = r & sec_clr;
  assign bus.mode       = state_q;
  assign bus.blink_mask = mask_q;
  assign bus.running    = running_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: directed stimulus, literal expectations and a cycle model.
module tb_clock_time_ctrl;
  localparam int HOLD = 8;
  localparam int RPT  = 3;
  localparam int BLK  = 4;

  logic clk = 1'b0;
  logic r;
  logic chk_on = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  clock_time_ctrl_if bus();

  clock_time_ctrl #(
    .CNT_W(24),
    .HOLD_CYC(24'd8),
    .REPEAT_CYC(24'd3),
    .BLINK_CYC(24'd4)
  ) dut (
    .clk(clk),
    .r(r),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: mode number, button history, cycles since press edge, cycles since blink restart.
  int m_mode = 0;
  bit m_prev = 1'b0;
  int m_age  = 0;
  int m_bage = 0;

  function automatic bit m_inc();
    int a;
    if (!bus.btn_inc) return 1'b0;
    a = m_prev ? m_age : 0;
    return (a == 0) || (a == HOLD) || (a > HOLD && ((a - HOLD) % RPT) == 0);
  endfunction

  function automatic logic [9:0] m_expect();
    logic se, me, he, sc;
    logic [2:0] mk;
    bit i;
    se = 0; me = 0; he = 0; sc = 0; mk = 3'b000;
    if (!r) return {4'b0000, 2'b00, 3'b000, 1'b1};
    i = m_inc();
    case (m_mode)
      0: begin se = bus.tick; me = bus.sec_co; he = bus.min_co; end
      1: he = i;
      2: me = i;
      default: sc = i;
    endcase
    if (m_mode != 0 && ((m_bage / BLK) % 2) == 1) begin
      case (m_mode)
        1: mk = 3'b100;
        2: mk = 3'b010;
        default: mk = 3'b001;
      endcase
    end
    return {se, me, he, sc, 2'(m_mode), mk, (m_mode == 0)};
  endfunction

  always @(posedge clk or negedge r) begin
    if (!r) begin
      m_mode <= 0; m_prev <= 1'b0; m_age <= 0; m_bage <= 0;
    end else begin
      if (bus.btn_mode) m_mode <= (m_mode + 1) % 4;
      if (bus.btn_mode || (m_inc() && m_mode != 0)) m_bage <= 0;
      else if (m_mode != 0) m_bage <= m_bage + 1;
      m_prev <= bus.btn_inc;
      if (bus.btn_inc && !m_prev) m_age <= 1;
      else if (bus.btn_inc)       m_age <= m_age + 1;
      else                        m_age <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Every cycle: compare all outputs with the model away from the active edge.
  always @(negedge clk) begin
    if (chk_on)
      check("cycle", {bus.sec_en, bus.min_en, bus.hr_en, bus.sec_clr, bus.mode,
                      bus.blink_mask, bus.running}, m_expect());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic t, input logic m, input logic i, input logic sc, input logic mc);
    bus.tick = t; bus.btn_mode = m; bus.btn_inc = i; bus.sec_co = sc; bus.min_co = mc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_blk[12] = '{0, 0, 0, 0, 0, 4, 4, 0, 0, 0, 0, 4};
    logic [14:0] hv;

    r = 1'b1;
    drive(1, 0, 0, 0, 1);
    #2 r = 1'b0;
    #1;
    check("rst_sec_en", bus.sec_en, 0);
    check("rst_hr_en", bus.hr_en, 0);
    check("rst_mode", bus.mode, 0);
    check("rst_mask", bus.blink_mask, 0);
    check("rst_running", bus.running, 1);
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #3 r = 1'b1;

    // RUN: tick with seconds carry, then minutes carry.
    step(); drive(1, 0, 0, 1, 0); #2;
    check("run_sec_en", bus.sec_en, 1);
    check("run_min_en", bus.min_en, 1);
    check("run_hr_en0", bus.hr_en, 0);
    step(); drive(0, 0, 0, 0, 1); #2;
    check("run_hr_en", bus.hr_en, 1);

    // Enter SET_HR with a simultaneous tick: tick still counted.
    step(); drive(1, 1, 0, 0, 0); #2;
    check("tick_at_enter", bus.sec_en, 1);

    // SET_HR idle blink, inc during blank phase at cycle 6 restarts the period.
    for (int i = 1; i <= 11; i++) begin
      step(); drive(i == 1, 0, i == 6, 0, 0); #2;
      if (i == 1) begin
        check("sethr_mode", bus.mode, 1);
        check("sethr_running", bus.running, 0);
        check("sethr_tick_drop", bus.sec_en, 0);
      end
      if (i == 6) check("blink_inc_hr", bus.hr_en, 1);
      check($sformatf("blink_%0d", i), bus.blink_mask, exp_blk[i]);
    end
    step(); drive(0, 0, 0, 0, 0);

    // Hold-to-repeat: held 15 cycles from the edge.
    for (int k = 0; k < 15; k++) begin
      step(); drive(0, 0, 1, 0, 0); #2;
      hv[k] = bus.hr_en;
    end
    check("hold_pulses", hv, 15'b100100100000001);
    step(); drive(0, 0, 0, 0, 0);
    step(); drive(0, 0, 1, 0, 0); #2;
    check("repress", bus.hr_en, 1);
    step(); drive(0, 0, 0, 0, 0);

    // SET_MIN: press with minute carry asserted.
    step(); drive(0, 1, 0, 0, 0);
    step(); drive(0, 0, 0, 0, 0); #2;
    check("setmin_mode", bus.mode, 2);
    step(); drive(0, 0, 1, 0, 1); #2;
    check("setmin_min_en", bus.min_en, 1);
    check("setmin_hr_en", bus.hr_en, 0);
    step(); drive(0, 0, 1, 0, 1); #2;
    check("setmin_min_en2", bus.min_en, 0);
    check("setmin_hr_en2", bus.hr_en, 0);
    step(); drive(0, 0, 0, 0, 0);

    // SET_SEC: press clears seconds, tick dropped.
    step(); drive(0, 1, 0, 0, 0);
    step(); drive(0, 0, 0, 0, 0); #2;
    check("setsec_mode", bus.mode, 3);
    step(); drive(1, 0, 1, 0, 0); #2;
    check("setsec_clr", bus.sec_clr, 1);
    check("setsec_sec_en", bus.sec_en, 0);
    step(); drive(1, 0, 1, 0, 0); #2;
    check("setsec_clr2", bus.sec_clr, 0);
    step(); drive(0, 0, 0, 0, 0);

    // Back to RUN: first tick counts.
    step(); drive(0, 1, 0, 0, 0);
    step(); drive(0, 0, 0, 0, 0); #2;
    check("ret_mode", bus.mode, 0);
    check("ret_running", bus.running, 1);
    step(); drive(1, 0, 0, 0, 0); #2;
    check("ret_tick", bus.sec_en, 1);

    // Reset in the middle of SET_MIN with the button held.
    step(); drive(0, 1, 0, 0, 0);
    step(); drive(0, 1, 0, 0, 0);
    step(); drive(0, 0, 0, 0, 0); #2;
    check("pre_rst_mode", bus.mode, 2);
    step(); drive(0, 0, 1, 0, 1); #2;
    check("pre_rst_min_en", bus.min_en, 1);
    step(); drive(1, 0, 1, 0, 1);
    #2 r = 1'b0;
    #1;
    check("arst_mode", bus.mode, 0);
    check("arst_sec_en", bus.sec_en, 0);
    check("arst_min_en", bus.min_en, 0);
    check("arst_hr_en", bus.hr_en, 0);
    check("arst_running", bus.running, 1);
    step(); drive(0, 0, 0, 0, 0);
    #2 r = 1'b1;
    step(); drive(1, 0, 0, 0, 0); #2;
    check("post_rst_tick", bus.sec_en, 1);
    check("post_rst_mode", bus.mode, 0);
    step(); drive(0, 0, 0, 0, 0);
    repeat (3) step();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
